// File: rtl/ds1302_pkg.sv
// Shared DS1302 definitions: register map, command-byte fields, reset values,
// bus FSM states and BCD helpers used by both the controller and the responder.
package ds1302_pkg;

   localparam int NUM_REGS = 8;

   localparam logic [2:0] REG_SEC   = 3'd0;
   localparam logic [2:0] REG_MIN   = 3'd1;
   localparam logic [2:0] REG_HOUR  = 3'd2;
   localparam logic [2:0] REG_DATE  = 3'd3;
   localparam logic [2:0] REG_MONTH = 3'd4;
   localparam logic [2:0] REG_WEEK  = 3'd5;
   localparam logic [2:0] REG_YEAR  = 3'd6;
   localparam logic [2:0] REG_WP    = 3'd7;

   localparam int CMD_RW_BIT   = 0;
   localparam int CMD_ADDR_LSB = 1;
   localparam int CMD_ADDR_MSB = 5;
   localparam int CMD_RAM_BIT  = 6;
   localparam int CMD_B7_BIT   = 7;

   localparam int WP_BIT = 7;
   localparam int CH_BIT = 7;

   localparam logic [7:0] RST_SEC   = 8'h00;
   localparam logic [7:0] RST_MIN   = 8'h00;
   localparam logic [7:0] RST_HOUR  = 8'h00;
   localparam logic [7:0] RST_DATE  = 8'h01;
   localparam logic [7:0] RST_MONTH = 8'h01;
   localparam logic [7:0] RST_WEEK  = 8'h01;
   localparam logic [7:0] RST_YEAR  = 8'h00;
   localparam logic [7:0] RST_WP    = 8'h80;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_WR,
      ST_RD,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [7:0] value;
      logic       wrap;
   } bcd_inc_t;

   function automatic logic [7:0] reg_reset_value(input logic [2:0] idx);
      case (idx)
         REG_SEC:   return RST_SEC;
         REG_MIN:   return RST_MIN;
         REG_HOUR:  return RST_HOUR;
         REG_DATE:  return RST_DATE;
         REG_MONTH: return RST_MONTH;
         REG_WEEK:  return RST_WEEK;
         REG_YEAR:  return RST_YEAR;
         default:   return RST_WP;
      endcase
   endfunction

   // Invalid BCD digits or values at/above the limit wrap to lo and report a wrap.
   function automatic bcd_inc_t bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                        input logic [7:0] hi);
      bcd_inc_t r;
      if (v[3:0] > 4'd9 || v[7:4] > 4'd9 || v >= hi) begin
         r.value = lo;
         r.wrap  = 1'b1;
      end else if (v[3:0] == 4'd9) begin
         r.value = {v[7:4] + 4'd1, 4'd0};
         r.wrap  = 1'b0;
      end else begin
         r.value = {v[7:4], v[3:0] + 4'd1};
         r.wrap  = 1'b0;
      end
      return r;
   endfunction

   function automatic logic bcd_leap(input logic [7:0] year);
      if (year[4])
         return (year[3:0] == 4'd2) || (year[3:0] == 4'd6);
      else
         return (year[3:0] == 4'd0) || (year[3:0] == 4'd4) || (year[3:0] == 4'd8);
   endfunction

   function automatic logic [7:0] month_days(input logic [7:0] month, input logic [7:0] year);
      case (month)
         8'h02:                      return bcd_leap(year) ? 8'h29 : 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
         default:                    return 8'h31;
      endcase
   endfunction

endpackage

// File: rtl/ds1302_responder_if.sv
// Register-file port between the bus FSM (master) and the RTC core (slave):
// a single-cycle write strobe plus a live view of all eight registers.
interface ds1302_responder_if;
   logic                                   wr_en;
   logic [2:0]                             wr_addr;
   logic [7:0]                             wr_data;
   logic [ds1302_pkg::NUM_REGS-1:0][7:0]   regs;

   modport master (output wr_en, output wr_addr, output wr_data, input  regs);
   modport slave  (input  wr_en, input  wr_addr, input  wr_data, output regs);
endinterface

// File: rtl/ds1302_rtc_core.sv
// DS1302 register file with write-protect gating and the one-cycle BCD
// carry chain driven by the 1 Hz tick.
module ds1302_rtc_core
   import ds1302_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick_1hz_i,
   ds1302_responder_if.slave  rf
);

   logic [7:0] regs_q [NUM_REGS];
   logic [7:0] regs_d [NUM_REGS];
   logic       tick_pend_q;
   logic       tick_pend_d;

   logic       tick_now;
   logic       commit;
   bcd_inc_t   sec_inc, min_inc, hour_inc, date_inc, week_inc, month_inc, year_inc;

   assign tick_now = tick_1hz_i | tick_pend_q;
   assign commit   = rf.wr_en & ((rf.wr_addr == REG_WP) | ~regs_q[REG_WP][WP_BIT]);

   assign sec_inc   = bcd_inc({1'b0, regs_q[REG_SEC][6:0]}, 8'h00, 8'h59);
   assign min_inc   = bcd_inc(regs_q[REG_MIN], 8'h00, 8'h59);
   assign hour_inc  = bcd_inc({1'b0, regs_q[REG_HOUR][6:0]}, 8'h00, 8'h23);
   assign date_inc  = bcd_inc(regs_q[REG_DATE], 8'h01,
                              month_days(regs_q[REG_MONTH], regs_q[REG_YEAR]));
   assign week_inc  = bcd_inc(regs_q[REG_WEEK], 8'h01, 8'h07);
   assign month_inc = bcd_inc(regs_q[REG_MONTH], 8'h01, 8'h12);
   assign year_inc  = bcd_inc(regs_q[REG_YEAR], 8'h00, 8'h99);

   // A commit shadows a coincident tick; the tick is replayed next cycle on the new values.
   always_comb begin
      regs_d      = regs_q;
      tick_pend_d = 1'b0;
      if (commit) begin
         if (rf.wr_addr == REG_WP)
            regs_d[REG_WP] = {rf.wr_data[WP_BIT], 7'b0};
         else
            regs_d[rf.wr_addr] = rf.wr_data;
         tick_pend_d = tick_now;
      end else if (tick_now && !regs_q[REG_SEC][CH_BIT]) begin
         regs_d[REG_SEC] = sec_inc.value;
         if (sec_inc.wrap) begin
            regs_d[REG_MIN] = min_inc.value;
            if (min_inc.wrap) begin
               // Hour bit 7 is storage only; it rides along unchanged.
               regs_d[REG_HOUR] = hour_inc.value | {regs_q[REG_HOUR][7], 7'b0};
               if (hour_inc.wrap) begin
                  regs_d[REG_DATE] = date_inc.value;
                  regs_d[REG_WEEK] = week_inc.value;
                  if (date_inc.wrap) begin
                     regs_d[REG_MONTH] = month_inc.value;
                     if (month_inc.wrap)
                        regs_d[REG_YEAR] = year_inc.value;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs_q[i] <= reg_reset_value(3'(i));
         tick_pend_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++)
            regs_q[i] <= regs_d[i];
         tick_pend_q <= tick_pend_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
         assign rf.regs[gi] = regs_q[gi];
      end
   endgenerate

endmodule

// File: rtl/ds1302_responder.sv
// DS1302 slave on the CE/SCLK/IO bus: synchronizers, bus FSM for single-byte
// clock-register transfers, and the RTC core holding time and write-protect.
module ds1302_responder
   import ds1302_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ds1302_ce,
   input  logic       ds1302_sclk,
   inout  wire        ds1302_io,
   input  logic       tick_1hz,
   output logic       io_oe,
   output logic [7:0] cur_second,
   output logic [7:0] cur_minute,
   output logic [7:0] cur_hour,
   output logic [7:0] cur_date,
   output logic [7:0] cur_month,
   output logic [7:0] cur_week,
   output logic [7:0] cur_year,
   output logic       write_protect
);

   // CE/SCLK carry one extra history stage so edges compare the last two samples.
   logic [1:0] ctl_sync_q [SYNC_STAGES+1];
   logic       io_sync_q  [SYNC_STAGES];

   genvar gi;
   generate
      for (gi = 0; gi <= SYNC_STAGES; gi++) begin : g_ctl_sync
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               ctl_sync_q[gi] <= 2'b00;
            else if (gi == 0)
               ctl_sync_q[gi] <= {ds1302_ce, ds1302_sclk};
            else
               ctl_sync_q[gi] <= ctl_sync_q[(gi == 0) ? 0 : gi-1];
         end
      end
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_io_sync
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               io_sync_q[gi] <= 1'b0;
            else if (gi == 0)
               io_sync_q[gi] <= ds1302_io;
            else
               io_sync_q[gi] <= io_sync_q[(gi == 0) ? 0 : gi-1];
         end
      end
   endgenerate

   logic [1:0] ctl_new, ctl_old;
   logic       ce_rise, ce_fall, sclk_rise, sclk_fall, io_bit;

   assign ctl_new   = ctl_sync_q[SYNC_STAGES-1];
   assign ctl_old   = ctl_sync_q[SYNC_STAGES];
   assign ce_rise   =  ctl_new[1] & ~ctl_old[1];
   assign ce_fall   = ~ctl_new[1] &  ctl_old[1];
   assign sclk_rise =  ctl_new[0] & ~ctl_old[0];
   assign sclk_fall = ~ctl_new[0] &  ctl_old[0];
   assign io_bit    = io_sync_q[SYNC_STAGES-1];

   ds1302_responder_if rf_if ();

   ds1302_rtc_core u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_1hz_i (tick_1hz),
      .rf         (rf_if.slave)
   );

   state_e     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shift_q, shift_d;
   logic [2:0] addr_q, addr_d;
   logic [7:0] snap_q, snap_d;
   logic       io_oe_q, io_oe_d;
   logic       io_out_q, io_out_d;

   logic [7:0] shift_next;
   logic       cmd_ok;
   logic       wr_en;

   assign shift_next = {io_bit, shift_q};
   assign cmd_ok     = shift_next[CMD_B7_BIT] & ~shift_next[CMD_RAM_BIT]
                     & (shift_next[CMD_ADDR_MSB:CMD_ADDR_LSB] <= 5'd7);

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      addr_d    = addr_q;
      snap_d    = snap_q;
      io_oe_d   = io_oe_q;
      io_out_d  = io_out_q;
      wr_en     = 1'b0;
      if (ce_fall) begin
         state_d = ST_IDLE;
         io_oe_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ce_rise) begin
                  bit_cnt_d = 4'd0;
                  state_d   = ST_CMD;
               end
            end
            ST_CMD: begin
               if (sclk_rise) begin
                  shift_d = shift_next[7:1];
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d = 4'd0;
                     addr_d    = shift_next[3:1];
                     if (cmd_ok && shift_next[CMD_RW_BIT]) begin
                        snap_d  = rf_if.regs[shift_next[3:1]];
                        state_d = ST_RD;
                     end else if (cmd_ok) begin
                        state_d = ST_WR;
                     end else begin
                        state_d = ST_DONE;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            ST_WR: begin
               if (sclk_rise) begin
                  shift_d = shift_next[7:1];
                  if (bit_cnt_q == 4'd7) begin
                     wr_en   = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            ST_RD: begin
               if (sclk_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     io_oe_d = 1'b0;
                     state_d = ST_DONE;
                  end else begin
                     io_oe_d   = 1'b1;
                     io_out_d  = snap_q[bit_cnt_q[2:0]];
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            ST_DONE: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= 4'd0;
         shift_q   <= 7'd0;
         addr_q    <= 3'd0;
         snap_q    <= 8'd0;
         io_oe_q   <= 1'b0;
         io_out_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         addr_q    <= addr_d;
         snap_q    <= snap_d;
         io_oe_q   <= io_oe_d;
         io_out_q  <= io_out_d;
      end
   end

   assign rf_if.wr_en   = wr_en;
   assign rf_if.wr_addr = addr_q;
   assign rf_if.wr_data = shift_next;

   assign ds1302_io     = io_oe_q ? io_out_q : 1'bz;
   assign io_oe         = io_oe_q;
   assign cur_second    = rf_if.regs[REG_SEC];
   assign cur_minute    = rf_if.regs[REG_MIN];
   assign cur_hour      = rf_if.regs[REG_HOUR];
   assign cur_date      = rf_if.regs[REG_DATE];
   assign cur_month     = rf_if.regs[REG_MONTH];
   assign cur_week      = rf_if.regs[REG_WEEK];
   assign cur_year      = rf_if.regs[REG_YEAR];
   assign write_protect = rf_if.regs[REG_WP][WP_BIT];

endmodule

// File: tb/tb_ds1302_responder.sv
// Directed bench for ds1302_responder: bit-bangs the 3-wire bus from the
// controller side and checks registers, read data and io_oe against hand values.
module tb_ds1302_responder;
   import ds1302_pkg::*;

   localparam int PH = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ce = 1'b0;
   logic       sclk = 1'b0;
   logic       io_drv = 1'b0;
   logic       io_drv_en = 1'b0;
   logic       tick = 1'b0;
   wire        io_w;
   logic       io_oe;
   logic [7:0] cur_second, cur_minute, cur_hour, cur_date, cur_month, cur_week, cur_year;
   logic       write_protect;

   int errors = 0;
   int checks = 0;

   assign io_w = io_drv_en ? io_drv : 1'bz;

   always #5 clk = ~clk;

   ds1302_responder #(.SYNC_STAGES(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ds1302_ce     (ce),
      .ds1302_sclk   (sclk),
      .ds1302_io     (io_w),
      .tick_1hz      (tick),
      .io_oe         (io_oe),
      .cur_second    (cur_second),
      .cur_minute    (cur_minute),
      .cur_hour      (cur_hour),
      .cur_date      (cur_date),
      .cur_month     (cur_month),
      .cur_week      (cur_week),
      .cur_year      (cur_year),
      .write_protect (write_protect)
   );

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      io_drv    = b;
      io_drv_en = 1'b1;
      sclk      = 1'b0;
      clks(PH);
      sclk      = 1'b1;
      clks(PH);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
   endtask

   task automatic ce_start;
      sclk = 1'b0;
      ce   = 1'b1;
      clks(PH);
   endtask

   task automatic ce_end;
      sclk = 1'b0;
      clks(PH);
      ce        = 1'b0;
      io_drv_en = 1'b0;
      clks(PH);
   endtask

   task automatic wr_reg(input logic [7:0] cmd, input logic [7:0] data);
      ce_start;
      send_byte(cmd);
      send_byte(data);
      ce_end;
      $display("write cmd=%02h data=%02h", cmd, data);
   endtask

   task automatic pulse_tick;
      tick = 1'b1;
      clks(1);
      tick = 1'b0;
   endtask

   task automatic test_reset;
      clks(4);
      rst_n = 1'b1;
      clks(3);
      checks += 10;
      if (cur_second !== 8'h00) begin errors++; $display("FAIL reset_sec: got %02h want 00", cur_second); end
      if (cur_minute !== 8'h00) begin errors++; $display("FAIL reset_min: got %02h want 00", cur_minute); end
      if (cur_hour   !== 8'h00) begin errors++; $display("FAIL reset_hour: got %02h want 00", cur_hour); end
      if (cur_date   !== 8'h01) begin errors++; $display("FAIL reset_date: got %02h want 01", cur_date); end
      if (cur_month  !== 8'h01) begin errors++; $display("FAIL reset_month: got %02h want 01", cur_month); end
      if (cur_week   !== 8'h01) begin errors++; $display("FAIL reset_week: got %02h want 01", cur_week); end
      if (cur_year   !== 8'h00) begin errors++; $display("FAIL reset_year: got %02h want 00", cur_year); end
      if (write_protect !== 1'b1) begin errors++; $display("FAIL reset_wp: got %b want 1", write_protect); end
      if (io_oe !== 1'b0) begin errors++; $display("FAIL reset_io_oe: got %b want 0", io_oe); end
      if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
      $display("reset released");
   endtask

   task automatic test_wp_write;
      wr_reg(8'h8E, 8'h00);
      checks++;
      if (write_protect !== 1'b0) begin errors++; $display("FAIL wp_clear: got %b want 0", write_protect); end
      wr_reg(8'h80, 8'h45);
      checks++;
      if (cur_second !== 8'h45) begin errors++; $display("FAIL sec_write: got %02h want 45", cur_second); end
   endtask

   task automatic test_wp_protect;
      wr_reg(8'h8E, 8'h80);
      checks++;
      if (write_protect !== 1'b1) begin errors++; $display("FAIL wp_set: got %b want 1", write_protect); end
      wr_reg(8'h82, 8'h30);
      checks++;
      if (cur_minute !== 8'h00) begin errors++; $display("FAIL min_protected: got %02h want 00", cur_minute); end
      wr_reg(8'h8E, 8'h00);
      wr_reg(8'h82, 8'h30);
      checks++;
      if (cur_minute !== 8'h30) begin errors++; $display("FAIL min_unprotected: got %02h want 30", cur_minute); end
   endtask

   task automatic preload(input logic [7:0] year);
      wr_reg(8'h80, 8'h59);
      wr_reg(8'h82, 8'h59);
      wr_reg(8'h84, 8'h23);
      wr_reg(8'h86, 8'h28);
      wr_reg(8'h88, 8'h02);
      wr_reg(8'h8A, 8'h07);
      wr_reg(8'h8C, year);
   endtask

   task automatic test_rollover;
      preload(8'h24);
      pulse_tick;
      $display("tick at 23:59:59 28-Feb-24");
      checks += 7;
      if (cur_second !== 8'h00) begin errors++; $display("FAIL leap_sec: got %02h want 00", cur_second); end
      if (cur_minute !== 8'h00) begin errors++; $display("FAIL leap_min: got %02h want 00", cur_minute); end
      if (cur_hour   !== 8'h00) begin errors++; $display("FAIL leap_hour: got %02h want 00", cur_hour); end
      if (cur_date   !== 8'h29) begin errors++; $display("FAIL leap_date: got %02h want 29", cur_date); end
      if (cur_month  !== 8'h02) begin errors++; $display("FAIL leap_month: got %02h want 02", cur_month); end
      if (cur_week   !== 8'h01) begin errors++; $display("FAIL leap_week: got %02h want 01", cur_week); end
      if (cur_year   !== 8'h24) begin errors++; $display("FAIL leap_year: got %02h want 24", cur_year); end
      preload(8'h23);
      pulse_tick;
      $display("tick at 23:59:59 28-Feb-23");
      checks += 7;
      if (cur_second !== 8'h00) begin errors++; $display("FAIL nonleap_sec: got %02h want 00", cur_second); end
      if (cur_minute !== 8'h00) begin errors++; $display("FAIL nonleap_min: got %02h want 00", cur_minute); end
      if (cur_hour   !== 8'h00) begin errors++; $display("FAIL nonleap_hour: got %02h want 00", cur_hour); end
      if (cur_date   !== 8'h01) begin errors++; $display("FAIL nonleap_date: got %02h want 01", cur_date); end
      if (cur_month  !== 8'h03) begin errors++; $display("FAIL nonleap_month: got %02h want 03", cur_month); end
      if (cur_week   !== 8'h01) begin errors++; $display("FAIL nonleap_week: got %02h want 01", cur_week); end
      if (cur_year   !== 8'h23) begin errors++; $display("FAIL nonleap_year: got %02h want 23", cur_year); end
   endtask

   task automatic test_read;
      logic [7:0] exp_v;
      logic [7:0] got;
      logic       oe_all;
      exp_v  = 8'h17;
      got    = 8'h00;
      oe_all = 1'b1;
      wr_reg(8'h84, 8'h17);
      ce_start;
      send_byte(8'h85);
      io_drv_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sclk = 1'b0;
         clks(PH);
         got[i] = io_w;
         oe_all = oe_all & io_oe;
         checks++;
         if (io_w !== exp_v[i]) begin errors++; $display("FAIL read_bit%0d: got %b want %b", i, io_w, exp_v[i]); end
         sclk = 1'b1;
         clks(PH);
      end
      sclk = 1'b0;
      clks(PH);
      checks += 2;
      if (oe_all !== 1'b1) begin errors++; $display("FAIL read_oe_during: got %b want 1", oe_all); end
      if (io_oe !== 1'b0) begin errors++; $display("FAIL read_oe_9th_fall: got %b want 0", io_oe); end
      ce = 1'b0;
      clks(PH);
      $display("read cmd=85 data=%02h", got);
   endtask

   task automatic test_partial_write;
      logic [7:0] data;
      data = 8'h12;
      ce_start;
      send_byte(8'h84);
      for (int i = 0; i < 4; i++) send_bit(data[i]);
      ce = 1'b0;
      io_drv_en = 1'b0;
      clks(PH);
      sclk = 1'b0;
      clks(PH);
      $display("aborted write cmd=84 after 4 bits");
      checks += 3;
      if (cur_hour !== 8'h17) begin errors++; $display("FAIL partial_hour: got %02h want 17", cur_hour); end
      if (io_oe !== 1'b0) begin errors++; $display("FAIL partial_io_oe: got %b want 0", io_oe); end
      if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL partial_state: got %0d want IDLE", dut.state_q); end
      wr_reg(8'h84, 8'h12);
      checks++;
      if (cur_hour !== 8'h12) begin errors++; $display("FAIL after_partial_hour: got %02h want 12", cur_hour); end
   endtask

   task automatic test_tick_on_commit;
      logic [7:0] data;
      data = 8'h10;
      ce_start;
      send_byte(8'h80);
      for (int i = 0; i < 7; i++) send_bit(data[i]);
      io_drv = data[7];
      sclk   = 1'b0;
      clks(PH);
      sclk   = 1'b1;
      // Rise event is acted on at the third edge after the pin; tick lands on that edge.
      clks(2);
      tick = 1'b1;
      clks(1);
      tick = 1'b0;
      checks++;
      if (cur_second !== 8'h10) begin errors++; $display("FAIL collide_commit: got %02h want 10", cur_second); end
      clks(1);
      checks++;
      if (cur_second !== 8'h11) begin errors++; $display("FAIL collide_pending: got %02h want 11", cur_second); end
      clks(PH - 4);
      ce_end;
      $display("write cmd=80 data=10 with tick on commit");
   endtask

   task automatic test_clock_halt;
      wr_reg(8'h80, 8'h80);
      checks++;
      if (cur_second !== 8'h80) begin errors++; $display("FAIL ch_write: got %02h want 80", cur_second); end
      pulse_tick;
      clks(2);
      checks++;
      if (cur_second !== 8'h80) begin errors++; $display("FAIL ch_tick: got %02h want 80", cur_second); end
      wr_reg(8'h80, 8'h00);
   endtask

   task automatic test_ram_cmd;
      logic seen;
      seen = 1'b0;
      ce_start;
      send_byte(8'hC1);
      io_drv_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sclk = 1'b0;
         clks(PH);
         seen = seen | io_oe;
         sclk = 1'b1;
         clks(PH);
      end
      checks += 2;
      if (dut.state_q !== ST_DONE) begin errors++; $display("FAIL ram_state: got %0d want DONE", dut.state_q); end
      ce_end;
      if (seen !== 1'b0) begin errors++; $display("FAIL ram_no_drive: got %b want 0", seen); end
      $display("ram cmd=C1 ignored");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_wp_write;
      test_wp_protect;
      test_rollover;
      test_read;
      test_partial_write;
      test_tick_on_commit;
      test_clock_halt;
      test_ram_cmd;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
